// File: rtl/common_fifo_ctrl32.sv
// ============================================================================
// Module   : common_fifo_ctrl32
// Purpose  : 32-entry in-order FIFO with valid/ready on both ports and a
//            fall-through head; pointers carry a wrap bit to tell full/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module common_fifo_ctrl32 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [DATA_WIDTH-1:0] deq_data,
    output logic [5:0]            count,
    output logic                  full,
    output logic                  empty,
    output logic [5:0]            wptr,
    output logic [5:0]            rptr
);

    localparam int c_DEPTH = 32;

    logic [5:0]            wptr_q;
    logic [5:0]            wptr_d;
    logic [5:0]            rptr_q;
    logic [5:0]            rptr_d;
    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

    logic w_enq_fire;
    logic w_deq_fire;

    // Index increments with a carry out of bit 4; the carry flips the wrap bit.
    function automatic logic [5:0] ptr_advance(input logic [5:0] p);
        logic [4:0] idx;
        logic       carry;
        {carry, idx} = {1'b0, p[4:0]} + 6'd1;
        return {p[5] ^ carry, idx};
    endfunction

    // Status derives only from registered pointers, so no input reaches an
    // output combinationally.
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[4:0] == rptr_q[4:0]) && (wptr_q[5] != rptr_q[5]);
    assign count     = wptr_q - rptr_q;
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign wptr      = wptr_q;
    assign rptr      = rptr_q;
    assign deq_data  = mem_q[rptr_q[4:0]];

    assign w_enq_fire = enq_valid & enq_ready;
    assign w_deq_fire = deq_valid & deq_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = 6'd0;
            rptr_d = 6'd0;
        end else begin
            if (w_enq_fire) begin
                wptr_d = ptr_advance(wptr_q);
            end
            if (w_deq_fire) begin
                rptr_d = ptr_advance(rptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= 6'd0;
            rptr_q <= 6'd0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_enq_fire) begin
            mem_q[wptr_q[4:0]] <= enq_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (reset || (count <= 6'd32));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_common_fifo_ctrl32.sv
// ============================================================================
// Module   : tb_common_fifo_ctrl32
// Purpose  : Directed bench with a data scoreboard for common_fifo_ctrl32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_common_fifo_ctrl32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [63:0] enq_data = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [63:0] deq_data;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic [5:0]  wptr;
    logic [5:0]  rptr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [5:0]  mw = 6'd0;
    logic [5:0]  mr = 6'd0;
    bit          model_ok = 1'b0;

    common_fifo_ctrl32 #(.DATA_WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .wptr      (wptr),
        .rptr      (rptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed dequeue must return the oldest accepted entry.
    always @(negedge clk) begin
        if (!reset && !flush && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL deq_underflow: got 0x%0h expected no dequeue", deq_data);
            end else begin
                chk("deq_data", deq_data, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; status is compared with the model before the edge.
    task automatic cycle(input bit ev, input logic [63:0] ed, input bit dr,
                         input bit fl, input bit rs);
        logic [5:0] mc;
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        mc = mw - mr;
        if (model_ok) begin
            chk("count", {58'd0, count}, {58'd0, mc});
            chk("wptr", {58'd0, wptr}, {58'd0, mw});
            chk("rptr", {58'd0, rptr}, {58'd0, mr});
            chk("full", {63'd0, full}, {63'd0, (mc == 6'd32)});
            chk("empty", {63'd0, empty}, {63'd0, (mc == 6'd0)});
            chk("enq_ready", {63'd0, enq_ready}, {63'd0, (mc != 6'd32)});
            chk("deq_valid", {63'd0, deq_valid}, {63'd0, (mc != 6'd0)});
        end
        if (rs || fl) begin
            mw = 6'd0;
            mr = 6'd0;
            exp_q.delete();
            if (rs) model_ok = 1'b1;
        end else begin
            if (ev && mc != 6'd32) begin
                exp_q.push_back(ed);
                mw = mw + 6'd1;
            end
            if (dr && mc != 6'd0) begin
                mr = mr + 6'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string name, input logic [5:0] w, input logic [5:0] r,
                        input logic [5:0] c);
        chk({name, ".wptr"}, {58'd0, wptr}, {58'd0, w});
        chk({name, ".rptr"}, {58'd0, rptr}, {58'd0, r});
        chk({name, ".count"}, {58'd0, count}, {58'd0, c});
        chk({name, ".empty"}, {63'd0, empty}, {63'd0, (c == 6'd0)});
        chk({name, ".full"}, {63'd0, full}, {63'd0, (c == 6'd32)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset held with a pending write that must be ignored.
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1);
        enq_valid = 1'b0;
        reset     = 1'b0;
        post("reset", 6'h00, 6'h00, 6'd0);
        chk("reset.enq_ready", {63'd0, enq_ready}, 64'd1);

        for (int i = 0; i < 32; i++) cycle(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0);
        post("fill", 6'h20, 6'h00, 6'd32);
        chk("fill.enq_ready", {63'd0, enq_ready}, 64'd0);
        cycle(1'b1, 64'hBAD, 1'b0, 1'b0, 1'b0);
        post("overfill", 6'h20, 6'h00, 6'd32);

        for (int i = 0; i < 32; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        post("drain", 6'h20, 6'h20, 6'd0);

        cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        post("flush0", 6'h00, 6'h00, 6'd0);

        // Park both pointers at 0x1E to exercise the index-31 wrap.
        for (int i = 0; i < 30; i++) cycle(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        post("park", 6'h1E, 6'h1E, 6'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 64'h300 + 64'(i), 1'b0, 1'b0, 1'b0);
            post("wrap_enq", 6'h1F + 6'(i), 6'h1E, 6'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
            post("wrap_deq", 6'h22, 6'h1F + 6'(i), 6'(3 - i));
        end

        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h400 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 64'h500 + 64'(i), 1'b1, 1'b0, 1'b0);
            chk("steady.count", {58'd0, count}, 64'd5);
        end

        for (int i = 0; i < 27; i++) cycle(1'b1, 64'h600 + 64'(i), 1'b0, 1'b0, 1'b0);
        chk("full32.count", {58'd0, count}, 64'd32);
        cycle(1'b1, 64'h700, 1'b1, 1'b0, 1'b0);
        chk("full_both.count", {58'd0, count}, 64'd31);
        chk("full_both.full", {63'd0, full}, 64'd0);

        cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b1, 64'h800 + 64'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush.count", {58'd0, count}, 64'd17);
        cycle(1'b1, 64'h900, 1'b1, 1'b1, 1'b0);
        post("flush17", 6'h00, 6'h00, 6'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        post("flush17_idle", 6'h00, 6'h00, 6'd0);

        // Reset while entries are buffered discards them.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'hA00 + 64'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        reset     = 1'b0;
        deq_ready = 1'b0;
        post("mid_reset", 6'h00, 6'h00, 6'd0);
        cycle(1'b1, 64'hB00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
